// File: rtl/neuron_mac_core.sv
// Fixed-point neuron: y = act(sum(a[i]*w[i]) + bias) over NINPUTS streamed operand pairs,
// with valid/ready streams, a run-time activation select and output saturation.
module neuron_mac_core #(
  parameter int DWIDTH  = 16,
  parameter int FRAC    = 8,
  parameter int NINPUTS = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DWIDTH-1:0] BIAS,
  input  logic [1:0]        ACT_MODE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DWIDTH-1:0] STREAM_A,
  input  logic [DWIDTH-1:0] STREAM_B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DWIDTH-1:0] STREAM_O,
  output logic              OVERFLOW,
  output logic              BUSY
);

  // Headroom for NINPUTS full-range products plus the aligned bias, so the sum never wraps.
  localparam int ACCW = 2*DWIDTH + $clog2(NINPUTS) + 2;
  localparam int CNTW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NINPUTS - 1);

  localparam logic signed [ACCW-1:0] ONE_VAL = ACCW'(1) << FRAC;
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ACT,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [1:0]               mode_q, mode_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]        stream_o_q, stream_o_d;
  logic                     overflow_q, overflow_d;
  logic                     busy_q, busy_d;

  logic signed [2*DWIDTH-1:0] prod;
  logic signed [ACCW-1:0]     prod_ext;
  logic signed [ACCW-1:0]     bias_ext;
  logic signed [ACCW-1:0]     shifted;
  logic signed [ACCW-1:0]     act_val;
  logic [DWIDTH-1:0]          sat_val;
  logic                       sat_ovf;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    prod     = $signed(STREAM_A) * $signed(STREAM_B);
    prod_ext = {{(ACCW-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
    bias_ext = {{(ACCW-DWIDTH){BIAS[DWIDTH-1]}}, BIAS} << FRAC;
    shifted  = acc_q >>> FRAC;

    act_val = shifted;
    case (mode_q)
      2'd0: act_val = shifted;
      2'd1: act_val = shifted[ACCW-1] ? '0 : shifted;
      2'd2: act_val = shifted[ACCW-1] ? (shifted >>> 3) : shifted;
      2'd3: begin
        if (shifted[ACCW-1])       act_val = '0;
        else if (shifted > ONE_VAL) act_val = ONE_VAL;
        else                       act_val = shifted;
      end
    endcase

    sat_ovf = 1'b0;
    sat_val = act_val[DWIDTH-1:0];
    if (act_val > SAT_MAX) begin
      sat_val = {1'b0, {(DWIDTH-1){1'b1}}};
      sat_ovf = 1'b1;
    end else if (act_val < SAT_MIN) begin
      sat_val = {1'b1, {(DWIDTH-1){1'b0}}};
      sat_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    stream_o_d = stream_o_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          acc_d   = bias_ext;
          mode_d  = ACT_MODE;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (IN_VALID && in_ready_q) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_ACT;
        end
      end
      S_ACT: begin
        stream_o_d = sat_val;
        overflow_d = sat_ovf;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_valid_q && OUT_READY) state_d = S_IDLE;
      end
    endcase

    // OUT_VALID rises on the second cycle in OUT, one cycle after the result is registered.
    in_ready_d  = (state_d == S_ACCUM);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_q == S_OUT) && (state_d == S_OUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stream_o_q  <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stream_o_q  <= stream_o_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign STREAM_O  = stream_o_q;
  assign OVERFLOW  = overflow_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/neuron_mac_core.md
Name: neuron_mac_core

Overview:
Parametrised successor to NeuronCore: one fixed-point neuron that computes y = act(sum(a[i]*w[i]) + bias) over NINPUTS streamed operand pairs.
- Operands and result are signed Q(DWIDTH-FRAC).FRAC.
- Input and output streams use valid/ready handshakes.
- Activation function is selectable at run time.
- Sits between the layer sequencer (drives START, streams activations and weights) and the next-layer buffer (consumes STREAM_O).

Parameters:
DWIDTH, 16, operand/result width, signed two's complement
FRAC, 8, fractional bits of operands, bias and result
NINPUTS, 8, operand pairs per neuron evaluation (>=1)
ACCW, 2*DWIDTH+$clog2(NINPUTS)+2, accumulator width (derived; do not override)

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  begin evaluation; sampled only in IDLE
BIAS  in  DWIDTH  bias, sampled on the accepted START
ACT_MODE  in  2  activation select, sampled on the accepted START
IN_VALID  in  1  STREAM_A/STREAM_B carry a valid pair
IN_READY  out  1  core accepts a pair this cycle
STREAM_A  in  DWIDTH  activation operand
STREAM_B  in  DWIDTH  weight operand
OUT_VALID  out  1  STREAM_O holds a result
OUT_READY  in  1  downstream accepts the result
STREAM_O  out  DWIDTH  activated, saturated result
OVERFLOW  out  1  result was saturated; valid with OUT_VALID
BUSY  out  1  state != IDLE

Behaviour:
- Interface: one clock (CLOCK); reset (RESET) is synchronous and active-high.
- Reset:
  - state=IDLE.
  - IN_READY=0, OUT_VALID=0, STREAM_O=0, OVERFLOW=0, BUSY=0.
  - Accumulator and beat counter cleared.
  - Reset mid-evaluation discards all partial state; no output is produced.
- FSM states: IDLE, ACCUM, ACT, OUT.
- IDLE:
  - START=1 -> acc = sign_ext(BIAS) <<< FRAC; latch ACT_MODE; cnt=0; go to ACCUM.
  - START is ignored in every other state.
- ACCUM:
  - IN_READY=1.
  - On IN_VALID&IN_READY: acc += signed(STREAM_A)*signed(STREAM_B) (full 2*DWIDTH product, sign-extended to ACCW); cnt++.
  - Accept on the beat where cnt==NINPUTS-1 -> ACT.
  - IN_VALID=0 cycles stall with no effect.
- ACT (one cycle, IN_READY=0):
  - s = acc >>> FRAC (arithmetic; truncates toward -inf).
  - Apply activation to s:
    - mode 0: identity.
    - mode 1: ReLU, max(s,0).
    - mode 2: leaky ReLU, s>=0 ? s : s>>>3.
    - mode 3: clamp to [0, 1<<FRAC].
  - Saturate to the signed DWIDTH range [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - OVERFLOW=1 iff saturation changed the value.
  - Register into STREAM_O -> OUT.
- OUT:
  - OUT_VALID=1; STREAM_O/OVERFLOW held stable until OUT_READY=1.
  - On OUT_READY: OUT_VALID drops next cycle; go to IDLE.
  - STREAM_O and OVERFLOW keep their last value in IDLE.
- Latency: last pair accepted at edge t -> OUT_VALID=1 after edge t+2. Minimum START-to-result is NINPUTS+2 cycles.
- Throughput: one evaluation in flight; next START is accepted no earlier than the cycle after the OUT handshake.
- Accumulator never wraps: ACCW covers NINPUTS full-range products plus bias.
- START and RESET asserted together: RESET wins.

Test Plan (DWIDTH=16, FRAC=8, NINPUTS=4):
1. Basic: START with BIAS=0x0080, mode 0; A=0x0100,0x0200,0x0300,0x0400; B=0x0100 each -> STREAM_O=0x0A80, OVERFLOW=0, OUT_VALID 2 cycles after the 4th beat.
2. Activation modes: same A, B=0xFF00 each, BIAS=0x0080:
   - mode 0 -> 0xF680.
   - mode 1 -> 0x0000.
   - mode 2 -> 0xFED0.
   - mode 3 -> 0x0000.
   - With B=0x0100 and mode 3 -> 0x0100.
3. Saturation: A=B=0x7F00 x4, BIAS=0, mode 0 -> STREAM_O=0x7FFF, OVERFLOW=1. A=0x8000, B=0x7F00 x4 -> 0x8000, OVERFLOW=1.
4. Handshake stress: random IN_VALID gaps, OUT_READY held low 5 cycles -> result of test 1 unchanged; STREAM_O stable while stalled; IN_READY=0 and START ignored during ACT/OUT.
5. Reset mid-op: RESET after 2 accepted beats -> all outputs 0 and BUSY=0 next cycle; rerun test 1 -> 0x0A80.
6. Back-to-back: two evaluations with START asserted the cycle after the OUT handshake -> both results correct, no beat lost or duplicated.
